wb_strobe_regbank: RTL and testbench



---
 rtl/wb_strobe_regbank.sv | 174 +++++++++++++++++
 tb/tb_wb_strobe_regbank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_strobe_regbank.sv
// Wishbone register bank: NREGS byte-maskable registers with per-register write/read
// strobes, error response on unmapped addresses and optional write/read pipelining.
module wb_strobe_regbank #(
  parameter int                     NREGS     = 4,
  parameter int                     WIDTH     = 32,
  parameter logic [NREGS*WIDTH-1:0] RESET_VAL = '0,
  parameter int                     PIPE_WR   = 1,
  parameter int                     PIPE_RD   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [3:0]             wb_adr_i,
  input  logic [3:0]             wb_sel_i,
  input  logic [31:0]            wb_dat_i,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  output logic                   wb_stall_o,
  output logic [31:0]            wb_dat_o,
  output logic [NREGS*WIDTH-1:0] regs_o,
  output logic [NREGS-1:0]       wr_o,
  output logic [NREGS-1:0]       rd_o
);

  localparam logic [4:0] NREGS_L = 5'(NREGS);

  logic        en, mapped, done;
  logic        rd_req, wr_req;
  logic        rip_q, rip_d, wip_q, wip_d;
  logic        wd_vld, wd_map;
  logic [3:0]  wd_adr, wd_sel;
  logic [31:0] wd_dat;
  logic [WIDTH-1:0] bmask;
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] wr_q;
  logic        wack_q, werr_q;
  logic        rack_p1_q, rerr_p1_q;
  logic [31:0] rdat_p1_q;
  logic        rack, rerr;
  logic [31:0] rdat;
  logic [31:0] rword [16];
  logic        unused_ok;

  assign en     = wb_cyc_i & wb_stb_i;
  assign mapped = ({1'b0, wb_adr_i} < NREGS_L);
  assign done   = wb_ack_o | wb_err_o;

  // A single busy pair blocks any new request until the outstanding one is answered
  assign rd_req = rst_n_i & en & ~wb_we_i & ~rip_q & ~wip_q;
  assign wr_req = rst_n_i & en &  wb_we_i & ~wip_q & ~rip_q;
  assign rip_d  = rd_req | (rip_q & ~done);
  assign wip_d  = wr_req | (wip_q & ~done);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rip_q <= 1'b0;
      wip_q <= 1'b0;
    end else begin
      rip_q <= rip_d;
      wip_q <= wip_d;
    end
  end

  // Write request stage: either registered once or decoded straight from the bus
  if (PIPE_WR != 0) begin : g_wpipe
    logic        vld_p1_q, map_p1_q;
    logic [3:0]  adr_p1_q, sel_p1_q;
    logic [31:0] dat_p1_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        vld_p1_q <= 1'b0;
        map_p1_q <= 1'b0;
        adr_p1_q <= '0;
        sel_p1_q <= '0;
        dat_p1_q <= '0;
      end else begin
        vld_p1_q <= wr_req;
        map_p1_q <= mapped;
        adr_p1_q <= wb_adr_i;
        sel_p1_q <= wb_sel_i;
        dat_p1_q <= wb_dat_i;
      end
    end
    assign wd_vld = vld_p1_q;
    assign wd_map = map_p1_q;
    assign wd_adr = adr_p1_q;
    assign wd_sel = sel_p1_q;
    assign wd_dat = dat_p1_q;
  end else begin : g_wdirect
    assign wd_vld = wr_req;
    assign wd_map = mapped;
    assign wd_adr = wb_adr_i;
    assign wd_sel = wb_sel_i;
    assign wd_dat = wb_dat_i;
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_mask
    assign bmask[k] = wd_sel[k/8];
  end

  // Decode stage: register file update and per-register strobes
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    logic [WIDTH-1:0] reg_q, reg_d;
    assign wr_hit[i] = wd_vld & wd_map & (wd_adr == 4'(i));
    assign reg_d     = wr_hit[i] ? ((reg_q & ~bmask) | (wd_dat[WIDTH-1:0] & bmask)) : reg_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) reg_q <= RESET_VAL[i*WIDTH +: WIDTH];
      else          reg_q <= reg_d;
    end
    assign regs_o[i*WIDTH +: WIDTH] = reg_q;
    assign rword[i] = 32'(reg_q);
    assign rd_o[i]  = rd_req & (wb_adr_i == 4'(i));
  end

  for (genvar i = NREGS; i < 16; i++) begin : g_unmapped
    assign rword[i] = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q      <= '0;
      wack_q    <= 1'b0;
      werr_q    <= 1'b0;
      rack_p1_q <= 1'b0;
      rerr_p1_q <= 1'b0;
      rdat_p1_q <= '0;
    end else begin
      wr_q      <= wr_hit;
      wack_q    <= wd_vld & wd_map;
      werr_q    <= wd_vld & ~wd_map;
      rack_p1_q <= rd_req & mapped;
      rerr_p1_q <= rd_req & ~mapped;
      rdat_p1_q <= rd_req ? rword[wb_adr_i] : '0;
    end
  end

  // Optional extra read response stage
  if (PIPE_RD != 0) begin : g_rpipe
    logic        rack_p2_q, rerr_p2_q;
    logic [31:0] rdat_p2_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        rack_p2_q <= 1'b0;
        rerr_p2_q <= 1'b0;
        rdat_p2_q <= '0;
      end else begin
        rack_p2_q <= rack_p1_q;
        rerr_p2_q <= rerr_p1_q;
        rdat_p2_q <= rdat_p1_q;
      end
    end
    assign rack = rack_p2_q;
    assign rerr = rerr_p2_q;
    assign rdat = rdat_p2_q;
  end else begin : g_rdirect
    assign rack = rack_p1_q;
    assign rerr = rerr_p1_q;
    assign rdat = rdat_p1_q;
  end

  assign wb_ack_o   = wack_q | rack;
  assign wb_err_o   = werr_q | rerr;
  assign wb_dat_o   = rdat;
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = en & ~done;
  assign wr_o       = wr_q;

  // Data bits above WIDTH and their byte selects are deliberately dropped
  assign unused_ok = ^{wd_dat, wd_sel};

endmodule

// File: tb/tb_wb_strobe_regbank.sv
// Bench for wb_strobe_regbank: two configurations driven from one bus, checked every
// cycle against a transaction-timestamp model plus directed literal expectations.
module tb_wb_strobe_regbank;

  localparam logic [63:0]  RV_A = 64'h0004_0003_0002_0001;
  localparam logic [127:0] RV_B = 128'h4444_4444_3333_3333_AABB_CCDD_1111_1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  adr = '0, sel = '0;
  logic [31:0] dat = '0;

  logic        ack_a, err_a, rty_a, stall_a, ack_b, err_b, rty_b, stall_b;
  logic [31:0] dat_a, dat_b;
  logic [3:0]  wr_a, wr_b, rd_a, rd_b;
  logic [63:0]  regs_a;
  logic [127:0] regs_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_strobe_regbank #(.NREGS(4), .WIDTH(16), .RESET_VAL(RV_A), .PIPE_WR(1), .PIPE_RD(1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat),
    .wb_ack_o(ack_a), .wb_err_o(err_a), .wb_rty_o(rty_a), .wb_stall_o(stall_a),
    .wb_dat_o(dat_a), .regs_o(regs_a), .wr_o(wr_a), .rd_o(rd_a));

  wb_strobe_regbank #(.NREGS(4), .WIDTH(32), .RESET_VAL(RV_B), .PIPE_WR(0), .PIPE_RD(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat),
    .wb_ack_o(ack_b), .wb_err_o(err_b), .wb_rty_o(rty_b), .wb_stall_o(stall_b),
    .wb_dat_o(dat_b), .regs_o(regs_b), .wr_o(wr_b), .rd_o(rd_b));

  // Per-instance model: configuration, register contents, and the one pending transaction
  int          wid   [2] = '{16, 32};
  int          lat_w [2] = '{2, 1};
  int          lat_r [2] = '{2, 1};
  logic [31:0] m_regs [2][4];
  bit          m_busy [2];
  int          m_due  [2];
  bit          m_we   [2];
  logic [3:0]  m_adr  [2];
  logic [3:0]  m_sel  [2];
  logic [31:0] m_dat  [2];
  int          cyc_n = 0;

  function automatic logic [31:0] rst_val(int k, int i);
    if (k == 0) return {16'h0, RV_A[i*16 +: 16]};
    return RV_B[i*32 +: 32];
  endfunction

  function automatic logic [31:0] dut_reg(int k, int i);
    if (k == 0) return {16'h0, regs_a[i*16 +: 16]};
    return regs_b[i*32 +: 32];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input int k, input logic ack, input logic err, input logic rty,
                            input logic stall, input logic [31:0] d, input logic [3:0] wr,
                            input logic [3:0] rd);
    bit          fin, mp, acc, e_ack, e_err, e_stall, regs_ok;
    logic [3:0]  e_wr, e_rd;
    logic [31:0] e_dat, bm, wmask, old;
    fin = 0; mp = 0; acc = 0; e_ack = 0; e_err = 0; e_wr = '0; e_rd = '0; e_dat = '0;
    wmask = (wid[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid[k]) - 32'd1);
    if (!rst_n) begin
      m_busy[k] = 0;
      for (int i = 0; i < 4; i++) m_regs[k][i] = rst_val(k, i);
    end else begin
      fin   = m_busy[k] && (m_due[k] == cyc_n);
      mp    = (m_adr[k] < 4'd4);
      e_ack = fin && mp;
      e_err = fin && !mp;
      if (fin && mp && m_we[k])  e_wr = 4'(1 << m_adr[k]);
      if (fin && mp && !m_we[k]) e_dat = m_dat[k];
      acc = cyc && stb && !m_busy[k];
      if (acc && !we && (adr < 4'd4)) e_rd = 4'(1 << adr);
    end
    e_stall = cyc && stb && !(e_ack || e_err);
    regs_ok = 1;
    for (int i = 0; i < 4; i++) if (dut_reg(k, i) !== m_regs[k][i]) regs_ok = 0;
    checks++;
    if (ack !== e_ack || err !== e_err || rty !== 1'b0 || stall !== e_stall || d !== e_dat ||
        wr !== e_wr || rd !== e_rd || !regs_ok) begin
      failures++;
      $display("FAIL model[%0d] cycle %0d: ack %b/%b err %b/%b rty %b stall %b/%b dat %h/%h wr %b/%b rd %b/%b regs %h %h %h %h / %h %h %h %h",
               k, cyc_n, ack, e_ack, err, e_err, rty, stall, e_stall, d, e_dat, wr, e_wr, rd, e_rd,
               dut_reg(k, 0), dut_reg(k, 1), dut_reg(k, 2), dut_reg(k, 3),
               m_regs[k][0], m_regs[k][1], m_regs[k][2], m_regs[k][3]);
    end
    if (rst_n) begin
      if (fin) m_busy[k] = 0;
      if (acc) begin
        m_busy[k] = 1;
        m_we[k]   = we;
        m_adr[k]  = adr;
        m_sel[k]  = sel;
        m_due[k]  = cyc_n + (we ? lat_w[k] : lat_r[k]);
        m_dat[k]  = we ? dat : ((adr < 4'd4) ? m_regs[k][adr[1:0]] : 32'h0);
      end
      if (m_busy[k] && m_we[k] && (m_due[k] - 1 == cyc_n) && (m_adr[k] < 4'd4)) begin
        bm  = {{8{m_sel[k][3]}}, {8{m_sel[k][2]}}, {8{m_sel[k][1]}}, {8{m_sel[k][0]}}};
        old = m_regs[k][m_adr[k][1:0]];
        m_regs[k][m_adr[k][1:0]] = ((old & ~bm) | (m_dat[k] & bm)) & wmask;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc_n++;
    model_step(0, ack_a, err_a, rty_a, stall_a, dat_a, wr_a, rd_a);
    model_step(1, ack_b, err_b, rty_b, stall_b, dat_b, wr_b, rd_b);
  end

  // One-cycle strobe; records response latency, data, error and strobes of both instances
  task automatic xfer(input bit w, input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                      output int la, output int lb, output logic [31:0] da, output logic [31:0] db,
                      output logic [3:0] wra, output logic [3:0] wrb, output logic [3:0] ra,
                      output logic [3:0] rb, output bit ea, output bit eb, output logic [1:0] st);
    la = -1; lb = -1; da = '0; db = '0; wra = '0; wrb = '0; ra = '0; rb = '0; ea = 0; eb = 0; st = '0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 0) begin ra = rd_a; rb = rd_b; st = {stall_a, stall_b}; end
      wra |= wr_a;
      wrb |= wr_b;
      if (la < 0 && (ack_a || err_a)) begin la = n; da = dat_a; ea = err_a; end
      if (lb < 0 && (ack_b || err_b)) begin lb = n; db = dat_b; eb = err_b; end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int la, lb;
    logic [31:0] da, db;
    logic [3:0]  wra, wrb, ra, rb;
    bit          ea, eb;
    logic [1:0]  st;
    logic [7:0]  seen;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_regs_a", 128'(regs_a), 128'(RV_A));
    check("reset_regs_b", regs_b, RV_B);
    check("reset_outputs", 128'({ack_a, err_a, ack_b, err_b, wr_a, wr_b, rd_a, rd_b, dat_a, dat_b}), 128'(0));

    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 4'(i), 4'hF, 32'h0, la, lb, da, db, wra, wrb, ra, rb, ea, eb, st);
      check("reset_read_a", 128'(da), 128'(i + 1));
      check("reset_read_lat", 128'({la, lb}), 128'({32'd2, 32'd1}));
    end
    xfer(1'b0, 4'd1, 4'h0, 32'h0, la, lb, da, db, wra, wrb, ra, rb, ea, eb, st);
    check("reset_read_b1", 128'(db), 128'(32'hAABB_CCDD));

    xfer(1'b1, 4'd2, 4'hF, 32'hDEAD_BEEF, la, lb, da, db, wra, wrb, ra, rb, ea, eb, st);
    check("wr2_lat", 128'({la, lb}), 128'({32'd2, 32'd1}));
    check("wr2_strobes", 128'({wra, wrb}), 128'(8'b0100_0100));
    check("wr2_reg_a", 128'(regs_a[47:32]), 128'(16'hBEEF));
    check("wr2_reg_b", 128'(regs_b[95:64]), 128'(32'hDEAD_BEEF));

    xfer(1'b1, 4'd1, 4'b0101, 32'h1122_3344, la, lb, da, db, wra, wrb, ra, rb, ea, eb, st);
    check("bytemask_b", 128'(regs_b[63:32]), 128'(32'hAA22_CC44));
    check("bytemask_a", 128'(regs_a[31:16]), 128'(16'h0044));
    check("bytemask_strobe", 128'({wra, wrb}), 128'(8'b0010_0010));
    xfer(1'b0, 4'd1, 4'h0, 32'h0, la, lb, da, db, wra, wrb, ra, rb, ea, eb, st);
    check("read_after_write", 128'({da, db}), 128'({32'h0000_0044, 32'hAA22_CC44}));

    xfer(1'b0, 4'd3, 4'hF, 32'h0, la, lb, da, db, wra, wrb, ra, rb, ea, eb, st);
    check("rd3_strobe", 128'({ra, rb}), 128'(8'b1000_1000));
    check("rd3_lat", 128'({la, lb}), 128'({32'd2, 32'd1}));
    check("rd3_stall", 128'(st), 128'(2'b11));

    xfer(1'b1, 4'd7, 4'hF, 32'h1234_5678, la, lb, da, db, wra, wrb, ra, rb, ea, eb, st);
    check("unmapped_wr_err", 128'({ea, eb, wra, wrb}), 128'(10'b11_0000_0000));
    check("unmapped_wr_lat", 128'({la, lb}), 128'({32'd2, 32'd1}));
    check("unmapped_wr_regs_a", 128'(regs_a), 128'(64'h0004_BEEF_0044_0001));
    check("unmapped_wr_regs_b", regs_b, 128'h4444_4444_DEAD_BEEF_AA22_CC44_1111_1111);
    xfer(1'b0, 4'd7, 4'hF, 32'h0, la, lb, da, db, wra, wrb, ra, rb, ea, eb, st);
    check("unmapped_rd", 128'({ea, eb, ra, rb, da, db}), 128'({2'b11, 8'h00, 64'h0}));
    check("unmapped_rd_lat", 128'({la, lb}), 128'({32'd2, 32'd1}));

    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd0; sel = 4'hF; dat = 32'h5555_6666;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; rst_n = 1'b0;
    seen = '0;
    @(negedge clk); seen |= {ack_a, err_a, ack_b, err_b, wr_a};
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); seen |= {ack_a, err_a, ack_b, err_b, wr_a};
    @(negedge clk); seen |= {ack_a, err_a, ack_b, err_b, wr_a};
    check("rst_mid_no_ack", 128'(seen), 128'(0));
    check("rst_mid_regs_a", 128'(regs_a), 128'(RV_A));
    check("rst_mid_regs_b", regs_b, RV_B);
    xfer(1'b1, 4'd0, 4'hF, 32'h5555_6666, la, lb, da, db, wra, wrb, ra, rb, ea, eb, st);
    check("rst_mid_next_wr", 128'({la, lb, regs_a[15:0], wra}), 128'({32'd2, 32'd1, 16'h6666, 4'b0001}));

    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      cyc   = ($urandom_range(0, 9) != 0);
      stb   = ($urandom_range(0, 3) != 0);
      we    = 1'($urandom_range(0, 1));
      adr   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      sel   = 4'($urandom);
      dat   = $urandom;
      rst_n = ($urandom_range(0, 299) != 0);
    end

    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
